// File: rtl/serv_immdec_w.sv
// serv_immdec_w: captures instruction bits [31:7] plus a format code, streams the 32-bit immediate W bits per beat.
// Latency: first beat is valid 1 cycle after i_wb_en; beats then advance one per accepted handshake.
// Backpressure: o_imm/o_imm_last hold while i_imm_ready=0; a new load or replay restarts at beat 0.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_wb_en, i_wb_rdt     load strobe and instruction bits [31:7]
//   i_fmt                 immediate format (0=I,1=S,2=B,3=U,4=J,5=CSR zimm,6/7=none)
//   i_restart             replay the stored immediate from beat 0
//   o_imm, o_imm_valid, i_imm_ready, o_imm_last   serial immediate stream
//   o_csr_imm             instruction bit 15
//   o_rd_addr, o_rs1_addr, o_rs2_addr             register address fields
//   o_imm_par             (only with SERV_IMMDEC_PAR_OUT_EN) whole stored immediate
//
// Optional feature macro: SERV_IMMDEC_PAR_OUT_EN (adds o_imm_par).

module serv_immdec_w #(
    parameter int W = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wb_en,
    input  logic [24:0]   i_wb_rdt,
    input  logic [2:0]    i_fmt,
    input  logic          i_restart,
    output logic [W-1:0]  o_imm,
    output logic          o_imm_valid,
    input  logic          i_imm_ready,
    output logic          o_imm_last,
    output logic          o_csr_imm,
`ifdef SERV_IMMDEC_PAR_OUT_EN
    output logic [31:0]   o_imm_par,
`endif
    output logic [4:0]    o_rd_addr,
    output logic [4:0]    o_rs1_addr,
    output logic [4:0]    o_rs2_addr
);

    localparam int N  = 32 / W;
    localparam int BW = $clog2(N);
    localparam logic [BW-1:0] BEAT_LAST = BW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // i_wb_rdt[k] holds instruction bit k+7, so ins[31] is r[24], ins[7] is r[0].
    function automatic logic [31:0] form_imm(input logic [24:0] r, input logic [2:0] f);
        logic [31:0] v;
        case (f)
            3'd0:    v = {{20{r[24]}}, r[24:13]};
            3'd1:    v = {{20{r[24]}}, r[24:18], r[4:0]};
            3'd2:    v = {{19{r[24]}}, r[24], r[0], r[23:18], r[4:1], 1'b0};
            3'd3:    v = {r[24:5], 12'b0};
            3'd4:    v = {{11{r[24]}}, r[24], r[12:5], r[13], r[23:14], 1'b0};
            3'd5:    v = {27'b0, r[12:8]};
            default: v = 32'b0;
        endcase
        return v;
    endfunction

    state_t          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [31:0]     imm_q, imm_d;
    logic            valid_q, valid_d;
    logic            csr_imm_q, csr_imm_d;
    logic [4:0]      rd_q, rd_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        imm_d     = imm_q;
        csr_imm_d = csr_imm_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;

        if (i_wb_en) begin
            // A load always wins and aborts any sequence in flight.
            state_d   = S_STREAM;
            beat_d    = '0;
            imm_d     = form_imm(i_wb_rdt, i_fmt);
            csr_imm_d = i_wb_rdt[8];
            rd_d      = i_wb_rdt[4:0];
            rs1_d     = i_wb_rdt[12:8];
            rs2_d     = i_wb_rdt[17:13];
        end else if (i_restart && (state_q != S_IDLE)) begin
            // Replay only makes sense once something has been loaded.
            state_d = S_STREAM;
            beat_d  = '0;
        end else if ((state_q == S_STREAM) && i_imm_ready) begin
            if (beat_q == BEAT_LAST) begin
                state_d = S_DONE;
                beat_d  = '0;
            end else begin
                beat_d  = beat_q + 1'b1;
            end
        end

        valid_d = (state_d == S_STREAM);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            imm_q     <= '0;
            valid_q   <= 1'b0;
            csr_imm_q <= 1'b0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            imm_q     <= imm_d;
            valid_q   <= valid_d;
            csr_imm_q <= csr_imm_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
        end
    end

    // Least significant slice first.
    assign o_imm       = imm_q[int'(beat_q) * W +: W];
    assign o_imm_valid = valid_q;
    assign o_imm_last  = valid_q & (beat_q == BEAT_LAST);
    assign o_csr_imm   = csr_imm_q;
    assign o_rd_addr   = rd_q;
    assign o_rs1_addr  = rs1_q;
    assign o_rs2_addr  = rs2_q;

`ifdef SERV_IMMDEC_PAR_OUT_EN
    assign o_imm_par = imm_q;
`endif

endmodule
